// File: rtl/pc_seq.sv
// Program counter sequencer: launches NUM_PROGS programs in turn, halts each at
// DONE_ADDR, and supports stalls, absolute/relative branches and call/return.
module pc_seq #(
    parameter int                          PC_W       = 16,
    parameter int                          NUM_PROGS  = 3,
    parameter logic [NUM_PROGS*PC_W-1:0]   PROG_BASES = {16'd301, 16'd124, 16'd67},
    parameter int                          DONE_ADDR  = 999,
    parameter int                          RAS_DEPTH  = 4,
    localparam int                         IDX_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             CLK,
    input  logic             Init,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Branch_abs,
    input  logic             Branch_rel_z,
    input  logic             Branch_rel_nz,
    input  logic             Call,
    input  logic             Ret,
    input  logic             ALU_zero,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  PC,
    output logic [IDX_W-1:0] Prog_idx,
    output logic             Running,
    output logic             DONE,
    output logic             All_done,
    output logic             Ras_err
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             all_done_q, all_done_d;
    logic             ras_err_q, ras_err_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic [PC_W-1:0]  ras_mem_q [RAS_DEPTH];

    logic             push_en;
    logic [PTR_W-1:0] push_ptr;
    logic [PTR_W-1:0] pop_ptr;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_rel;
    logic [PC_W-1:0]  base_sel;
    logic [PC_W-1:0]  base0;

    // Relative offsets are two's complement, so a plain modular add is exact.
    assign pc_inc   = pc_q + PC_W'(1);
    assign pc_rel   = pc_q + Target;
    assign push_ptr = ras_cnt_q[PTR_W-1:0];
    assign pop_ptr  = PTR_W'(ras_cnt_q - CNT_W'(1));
    assign base_sel = PROG_BASES[idx_q*PC_W +: PC_W];
    assign base0    = PROG_BASES[PC_W-1:0];

    always_ff @(posedge CLK or posedge Init) begin
        if (Init) begin
            state_q    <= S_IDLE;
            pc_q       <= base0;
            idx_q      <= '0;
            all_done_q <= 1'b0;
            ras_err_q  <= 1'b0;
            ras_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            idx_q      <= idx_d;
            all_done_q <= all_done_d;
            ras_err_q  <= ras_err_d;
            ras_cnt_q  <= ras_cnt_d;
        end
    end

    // Stack contents need no reset: the occupancy counter defines what is live.
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            always_ff @(posedge CLK) begin
                if (push_en && (push_ptr == PTR_W'(gi))) begin
                    ras_mem_q[gi] <= pc_inc;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        idx_d      = idx_q;
        all_done_d = all_done_q;
        ras_err_d  = ras_err_q;
        ras_cnt_d  = ras_cnt_q;
        push_en    = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    state_d    = S_RUN;
                    pc_d       = base_sel;
                    ras_cnt_d  = '0;
                    all_done_d = 1'b0;
                end
            end
            S_RUN: begin
                if (Stall) begin
                    pc_d = pc_q;
                end else if (pc_q == PC_W'(DONE_ADDR)) begin
                    state_d = S_HALT;
                    if (idx_q == IDX_W'(NUM_PROGS - 1)) begin
                        idx_d      = '0;
                        all_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (Ret) begin
                    if (ras_cnt_q != '0) begin
                        pc_d      = ras_mem_q[pop_ptr];
                        ras_cnt_d = ras_cnt_q - CNT_W'(1);
                    end else begin
                        pc_d      = pc_inc;
                        ras_err_d = 1'b1;
                    end
                end else if (Call) begin
                    // The jump is taken even when the return address cannot be kept.
                    pc_d = Target;
                    if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
                        push_en   = 1'b1;
                        ras_cnt_d = ras_cnt_q + CNT_W'(1);
                    end else begin
                        ras_err_d = 1'b1;
                    end
                end else if (Branch_abs) begin
                    pc_d = Target;
                end else if ((Branch_rel_z && ALU_zero) || (Branch_rel_nz && !ALU_zero)) begin
                    pc_d = pc_rel;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign PC       = pc_q;
    assign Prog_idx = idx_q;
    assign Running  = (state_q == S_RUN);
    assign DONE     = (state_q == S_HALT);
    assign All_done = all_done_q;
    assign Ras_err  = ras_err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a behavioural model predicts each cycle's outputs,
// a separate monitor compares them one cycle later.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        Init, Start, Stall, Branch_abs, Branch_rel_z, Branch_rel_nz;
    logic        Call, Ret, ALU_zero;
    logic [15:0] Target;
    logic [15:0] PC;
    logic [1:0]  Prog_idx;
    logic        Running, DONE, All_done, Ras_err;

    pc_seq dut (
        .CLK(clk), .Init(Init), .Start(Start), .Stall(Stall),
        .Branch_abs(Branch_abs), .Branch_rel_z(Branch_rel_z), .Branch_rel_nz(Branch_rel_nz),
        .Call(Call), .Ret(Ret), .ALU_zero(ALU_zero), .Target(Target),
        .PC(PC), .Prog_idx(Prog_idx), .Running(Running), .DONE(DONE),
        .All_done(All_done), .Ras_err(Ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [1:0]  idx;
        logic        run, done, alld, err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    // Reference model: mode 0 idle, 1 running, 2 halted; stack is a plain queue.
    int          m_mode;
    logic [15:0] m_pc;
    int          m_idx;
    logic        m_alld, m_err;
    logic [15:0] m_stk[$];

    function automatic logic [15:0] base_of(int i);
        case (i)
            0:       return 16'd67;
            1:       return 16'd124;
            default: return 16'd301;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = base_of(0); m_idx = 0; m_alld = 0; m_err = 0;
        m_stk.delete();
    endtask

    task automatic model_step();
        if (m_mode != 1) begin
            if (Start) begin
                m_mode = 1; m_pc = base_of(m_idx); m_stk.delete(); m_alld = 0;
            end
        end else if (Stall) begin
            m_mode = 1;
        end else if (m_pc == 16'd999) begin
            m_mode = 2;
            if (m_idx == 2) begin m_idx = 0; m_alld = 1; end
            else m_idx = m_idx + 1;
        end else if (Ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = m_pc + 16'd1; m_err = 1; end
        end else if (Call) begin
            if (m_stk.size() < 4) m_stk.push_back(m_pc + 16'd1);
            else m_err = 1;
            m_pc = Target;
        end else if (Branch_abs) begin
            m_pc = Target;
        end else if ((Branch_rel_z && ALU_zero) || (Branch_rel_nz && !ALU_zero)) begin
            m_pc = m_pc + Target;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic drive(input logic st, input logic sl, input logic ba, input logic rz,
                         input logic rnz, input logic ca, input logic re, input logic z,
                         input logic [15:0] tgt);
        exp_t e;
        @(negedge clk);
        Start = st; Stall = sl; Branch_abs = ba; Branch_rel_z = rz; Branch_rel_nz = rnz;
        Call = ca; Ret = re; ALU_zero = z; Target = tgt;
        model_step();
        e.pc = m_pc; e.idx = 2'(m_idx); e.run = (m_mode == 1); e.done = (m_mode == 2);
        e.alld = m_alld; e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic idle();                 drive(0,0,0,0,0,0,0,0,16'h0); endtask
    task automatic start();                drive(1,0,0,0,0,0,0,0,16'h0); endtask
    task automatic jump(input logic [15:0] t); drive(0,0,1,0,0,0,0,0,t); endtask
    task automatic call(input logic [15:0] t); drive(0,0,0,0,0,1,0,0,t); endtask
    task automatic ret();                  drive(0,0,0,0,0,0,1,0,16'h0); endtask

    // Monitor: outputs are presented every cycle; compare one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_txn++;
                $display("txn %0d: pc=%0d idx=%0d run=%0b done=%0b alld=%0b err=%0b",
                         n_txn, PC, Prog_idx, Running, DONE, All_done, Ras_err);
                chk("pc",       32'(PC),       32'(e.pc));
                chk("prog_idx", 32'(Prog_idx), 32'(e.idx));
                chk("running",  32'(Running),  32'(e.run));
                chk("done",     32'(DONE),     32'(e.done));
                chk("all_done", 32'(All_done), 32'(e.alld));
                chk("ras_err",  32'(Ras_err),  32'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Init = 1; Start = 0; Stall = 0; Branch_abs = 0; Branch_rel_z = 0; Branch_rel_nz = 0;
        Call = 0; Ret = 0; ALU_zero = 0; Target = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_pc",   32'(PC), 32'd67);
        chk("reset_idx",  32'(Prog_idx), 32'd0);
        chk("reset_run",  32'(Running), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_flags", 32'({All_done, Ras_err}), 32'd0);
        Init = 0;

        start(); idle(); idle();                       // 67, 68, 69

        @(negedge clk);
        Init = 1;
        #1;
        chk("async_pc",  32'(PC), 32'd67);
        chk("async_run", 32'(Running), 32'd0);
        model_reset();
        @(negedge clk);
        Init = 0;

        for (int p = 0; p < 3; p++) begin
            start(); jump(16'd999); idle(); idle();    // halt, then hold
        end

        start();
        jump(16'd100); drive(0,0,0,1,0,0,0,1,16'hFFFB);    // 95
        jump(16'd100); drive(0,0,0,1,0,0,0,0,16'hFFFB);    // 101
        drive(0,0,0,0,1,0,0,0,16'd5);                      // 106
        jump(16'd0);   drive(0,0,0,1,0,0,0,1,16'hFFFF);    // wraps to 0xFFFF

        jump(16'd70); call(16'd500); ret();                // 500, 71
        for (int i = 0; i < 5; i++) call(16'(600 + 10 * i));
        for (int i = 0; i < 5; i++) ret();

        for (int i = 0; i < 3; i++) drive(0,1,1,0,0,0,0,0,16'd800);
        jump(16'd999);
        drive(0,1,0,0,0,0,0,0,16'h0); drive(0,1,0,0,0,0,0,0,16'h0);
        idle(); idle();

        start(); drive(0,0,1,0,0,1,0,0,16'd400); ret();

        for (int i = 0; i < 400; i++) begin
            logic [15:0] t;
            t = ($urandom_range(0, 5) == 0) ? 16'd999 : 16'($urandom);
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 6) == 0, 1'($urandom), t);
        end

        idle(); idle();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
